acc_sched: RTL and testbench
============================

ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the accumulator.
REQ-002 SHALL have parameter DW, default 8, sample width.
REQ-003 SHALL have parameter SW, default 16, sum width.
REQ-004 SHALL have parameter LW, default 8, burst-length field width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  NREQ  per-requester burst request.
REQ-008 req_len  input  NREQ*LW  per-requester burst length, slice i for requester i.
REQ-009 req_data  input  NREQ*DW  per-requester sample, slice i for requester i.
REQ-010 req_valid  input  NREQ  per-requester sample valid.
REQ-011 gnt  output  NREQ  one-hot grant; zero when idle.
REQ-012 data_ready  output  1  accumulator accepts a sample from the granted requester this cycle.
REQ-013 res_valid  output  1  burst result available.
REQ-014 res_sum  output  SW  burst sum.
REQ-015 res_id  output  clog2(NREQ)  index of the requester that owns res_sum.
REQ-016 res_ready  input  1  result consumer accepts result.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, RESULT.
REQ-018 IDLE: if any req bit set, next edge -> ACCUM, gnt set to round-robin winner, length latched from winner's req_len, sum and count cleared.
REQ-019 Round-robin: search starts at index (last_served+1) mod NREQ; last_served resets to NREQ-1, so requester 0 has first priority.
REQ-020 Winner with latched length 0 -> RESULT directly, res_sum=0, no samples taken.
REQ-021 ACCUM: data_ready=1; each cycle with req_valid[winner]&&data_ready, sum += zero-extended req_data[winner], count++.
REQ-022 Inputs of non-granted requesters SHALL be ignored entirely.
REQ-023 Handshake completing count==len-1 SHALL move to RESULT next edge; res_valid=1 in that cycle, data_ready=0.
REQ-024 Sum SHALL be SW bits modulo 2^SW; with defaults (max 255*255) no wrap occurs.
REQ-025 RESULT: res_valid, res_sum, res_id held stable until res_valid&&res_ready; that edge -> IDLE, gnt cleared, last_served=winner.
REQ-026 Deassertion of req by the granted requester mid-burst SHALL NOT abort the burst; ownership ends only on result acceptance.
REQ-027 Minimum one IDLE cycle between bursts; a pending request is granted on the edge after IDLE is entered.
REQ-028 gnt stays asserted through ACCUM and RESULT.

Reset
REQ-029 rst asserted at any time SHALL asynchronously force IDLE, gnt=0, data_ready=0, res_valid=0, res_sum=0, res_id=0, count=0, last_served=NREQ-1; in-flight burst discarded.
REQ-030 First grant no earlier than first rising edge after rst deasserts.

Structure
REQ-031 Package acc_sched_pkg SHALL hold the state enum type and default NREQ/DW/SW/LW constants.
REQ-032 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs req, last_served; outputs one-hot grant, index), purely combinational.

Verification
REQ-033 Single burst: req[0]=1, len=3, samples 10,20,30 back-to-back -> res_valid with res_sum=60, res_id=0, 3 data_ready cycles.
REQ-034 Contention: req=4'b1111 continuous, len=1 each -> grants in order 0,1,2,3,0.
REQ-035 Valid gaps and backpressure: len=2, samples 255 then idle 3 cycles then 255, res_ready low 4 cycles -> res_sum=510 held stable until res_ready.
REQ-036 Zero length: req[2]=1, len=0 -> RESULT reached with res_sum=0, res_id=2, no data_ready.
REQ-037 Max burst: len=255, all samples 255 -> res_sum=65025.
REQ-038 Reset mid-burst: rst asserted after 2 of 5 samples -> outputs zero immediately; next burst from requester 0 (len=1, sample 7) yields res_sum=7.

Source files
------------

// File: rtl/acc_sched_pkg.sv
// Shared types and default sizing for the burst-accumulator scheduler.
package acc_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int SW_DEF   = 16;
    localparam int LW_DEF   = 8;

    // IDLE: waiting for requests; ACCUM: owner streams samples; RESULT: sum offered
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/acc_sched_rr_arbiter.sv
// Combinational round-robin pick: the search starts just after the last served
// requester and wraps, so every active requester is reached within NREQ bursts.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_served,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int   cand;
    logic found;

    // Walk the requesters in rotated order and take the first active one
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_served) + off) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/acc_sched.sv
// Shared accumulator: grants one requester at a time, sums a burst of its
// samples and offers the total until the consumer takes it.
//
// Handshakes: a sample transfers on a rising edge where req_valid[winner] and
// data_ready are both high; a result transfers on a rising edge where res_valid
// and res_ready are both high. res_valid/res_sum/res_id never change while
// res_valid is high and res_ready is low.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int LW   = LW_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*LW-1:0] req_len,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  gnt,
    output logic             data_ready,
    output logic             res_valid,
    output logic [SW-1:0]    res_sum,
    output logic [IW-1:0]    res_id,
    input  logic             res_ready
);

    // Internal state kept as a named variable so checkers can bind to it
    state_t          state;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   last_served;
    logic [LW-1:0]   len;
    logic [LW-1:0]   cnt;
    logic [SW-1:0]   sum;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [LW-1:0]   arb_len;
    logic [DW-1:0]   cur_sample;
    logic [SW-1:0]   sum_next;
    logic            take;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req         (req),
        .last_served (last_served),
        .grant       (arb_gnt),
        .idx         (arb_idx)
    );

    // Winner's length, owner's sample and the running sum after this sample
    always_comb begin
        arb_len    = req_len[int'(arb_idx)*LW +: LW];
        cur_sample = req_data[int'(win_idx)*DW +: DW];
        take       = (state == ACCUM) && data_ready && req_valid[win_idx];
        sum_next   = sum + SW'(cur_sample);
    end

    // Scheduler FSM with registered grant, handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            win_idx     <= '0;
            last_served <= IW'(NREQ - 1);
            len         <= '0;
            cnt         <= '0;
            sum         <= '0;
            data_ready  <= 1'b0;
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_id      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= arb_gnt;
                        win_idx <= arb_idx;
                        res_id  <= arb_idx;
                        len     <= arb_len;
                        sum     <= '0;
                        cnt     <= '0;
                        if (arb_len == '0) begin
                            // Empty burst: report a zero sum without taking samples
                            state      <= RESULT;
                            res_valid  <= 1'b1;
                            res_sum    <= '0;
                            data_ready <= 1'b0;
                        end else begin
                            state      <= ACCUM;
                            data_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (take) begin
                        sum <= sum_next;
                        cnt <= cnt + LW'(1);
                        if (cnt == len - LW'(1)) begin
                            state      <= RESULT;
                            data_ready <= 1'b0;
                            res_valid  <= 1'b1;
                            res_sum    <= sum_next;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        gnt         <= '0;
                        res_valid   <= 1'b0;
                        last_served <= win_idx;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched: one task per scenario, inline checks.
module tb_acc_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SW   = 16;
    localparam int LW   = 8;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    gnt;
    logic               data_ready;
    logic               res_valid;
    logic [SW-1:0]      res_sum;
    logic [IW-1:0]      res_id;
    logic               res_ready;

    int n_cmp = 0;
    int n_err = 0;

    acc_sched #(
        .NREQ (NREQ),
        .DW   (DW),
        .SW   (SW),
        .LW   (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .gnt        (gnt),
        .data_ready (data_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge only
    task automatic set_len(input int i, input logic [LW-1:0] v);
        req_len[i*LW +: LW] = v;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req       = '0;
        req_len   = '0;
        req_data  = '0;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (res_sum !== 16'd0) begin n_err++; $display("FAIL reset_res_sum: got %0d want 0", res_sum); end
        n_cmp++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
        // request waiting while in reset must not be granted before an edge
        @(negedge clk);
        req = 4'b1111;
        set_len(0, 8'd1); set_len(1, 8'd1); set_len(2, 8'd1); set_len(3, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_no_early_grant: got %b want 0000", gnt); end
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", gnt); end
        apply_reset();
    endtask

    task automatic test_single_burst();
        int dr_cycles;
        logic [DW-1:0] samples [3];
        samples = '{8'd10, 8'd20, 8'd30};
        dr_cycles = 0;
        @(negedge clk);
        req = 4'b0001;
        set_len(0, 8'd3);
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        req = 4'b0000;  // dropping req mid-burst must not abort
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (data_ready) dr_cycles++;
            req_valid[0] = 1'b1;
            set_data(0, samples[k]);
        end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (dr_cycles != 3) begin n_err++; $display("FAIL single_ready_cycles: got %0d want 3", dr_cycles); end
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
        n_cmp++; if (res_sum !== 16'd60) begin n_err++; $display("FAIL single_res_sum: got %0d want 60", res_sum); end
        n_cmp++; if (res_id !== 2'd0) begin n_err++; $display("FAIL single_res_id: got %0d want 0", res_id); end
        n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_in_result: got %b want 0", data_ready); end
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt_in_result: got %b want 0001", gnt); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_res_taken: got %b want 0", res_valid); end
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_cleared: got %b want 0000", gnt); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_g [5];
        int              exp_i [5];
        logic [NREQ-1:0] prev;
        int              got;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_len(i, 8'd1);
            set_data(i, DW'(10 * (i + 1)));
        end
        req       = 4'b1111;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        prev      = '0;
        got       = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (res_valid && got > 0) begin
                n_cmp++;
                if (res_sum !== SW'(10 * (exp_i[got-1] + 1)) || res_id !== IW'(exp_i[got-1])) begin
                    n_err++;
                    $display("FAIL contention_result: got id %0d sum %0d want id %0d sum %0d",
                             res_id, res_sum, exp_i[got-1], 10 * (exp_i[got-1] + 1));
                end
            end
            if (prev == '0 && gnt != '0) begin
                n_cmp++;
                if (gnt !== exp_g[got]) begin
                    n_err++;
                    $display("FAIL contention_grant%0d: got %b want %b", got, gnt, exp_g[got]);
                end
                got++;
            end
            prev = gnt;
        end
        n_cmp++; if (got != 5) begin n_err++; $display("FAIL contention_timeout: got %0d grants want 5", got); end
        apply_reset();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req = 4'b0010;
        set_len(1, 8'd2);
        set_len(0, 8'd9);
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL bp_gnt: got %b want 0010", gnt); end
        req          = 4'b0000;
        req_valid[1] = 1'b1;
        set_data(1, 8'd255);
        req_valid[0] = 1'b1;   // non-granted requester noise, must be ignored
        set_data(0, 8'd99);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_early_result: got %b want 0", res_valid); end
        @(negedge clk);
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b1 || res_sum !== 16'd510 || res_id !== 2'd1) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid %b sum %0d id %0d want valid 1 sum 510 id 1",
                         k, res_valid, res_sum, res_id);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || gnt !== 4'b0000) begin n_err++; $display("FAIL bp_release: got valid %b gnt %b want 0 0000", res_valid, gnt); end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        req = 4'b0100;
        set_len(2, 8'd0);
        @(negedge clk);
        req = 4'b0000;
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL zero_res_valid: got %b want 1", res_valid); end
        n_cmp++; if (res_sum !== 16'd0) begin n_err++; $display("FAIL zero_res_sum: got %0d want 0", res_sum); end
        n_cmp++; if (res_id !== 2'd2) begin n_err++; $display("FAIL zero_res_id: got %0d want 2", res_id); end
        n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL zero_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL zero_gnt: got %b want 0100", gnt); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL zero_release: got %b want 0", res_valid); end
    endtask

    task automatic test_max_burst();
        int  dr_cycles;
        logic done;
        dr_cycles = 0;
        done      = 1'b0;
        @(negedge clk);
        req = 4'b1000;
        set_len(3, 8'd255);
        set_data(3, 8'd255);
        req_valid[3] = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            req = 4'b0000;
            if (res_valid) done = 1'b1;
            else if (data_ready) dr_cycles++;
        end
        req_valid = '0;
        n_cmp++; if (!done) begin n_err++; $display("FAIL max_timeout: got no result want result"); end
        n_cmp++; if (dr_cycles != 255) begin n_err++; $display("FAIL max_ready_cycles: got %0d want 255", dr_cycles); end
        n_cmp++; if (res_sum !== 16'd65025) begin n_err++; $display("FAIL max_res_sum: got %0d want 65025", res_sum); end
        n_cmp++; if (res_id !== 2'd3) begin n_err++; $display("FAIL max_res_id: got %0d want 3", res_id); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        req = 4'b0010;
        set_len(1, 8'd5);
        @(negedge clk);
        req          = 4'b0000;
        req_valid[1] = 1'b1;
        set_data(1, 8'd3);
        @(negedge clk);
        set_data(1, 8'd4);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
        n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL midrst_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (res_valid !== 1'b0 || res_sum !== 16'd0 || res_id !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_result: got valid %b sum %0d id %0d want 0 0 0", res_valid, res_sum, res_id);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        set_len(0, 8'd1);
        set_data(0, 8'd7);
        req_valid[0] = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_regrant: got %b want 0001", gnt); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (res_valid !== 1'b1 || res_sum !== 16'd7 || res_id !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_next_burst: got valid %b sum %0d id %0d want 1 7 0", res_valid, res_sum, res_id);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_single_burst();
        test_contention();
        test_backpressure();
        test_zero_length();
        test_max_burst();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
